// File: rtl/mem_copy_engine.sv
// Byte copy engine that drives the data RAM port: read at src, write at dst, two cycles per byte.
// Define MEMCOPY_FILL_EN to add Fill/FillValue for a one-cycle-per-byte memory fill mode.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Abort,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Length,
`ifdef MEMCOPY_FILL_EN
  input  logic              Fill,
  input  logic [DATA_W-1:0] FillValue,
`endif
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] BytesLeft,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fill_mode;
  logic              fill_start;

`ifdef MEMCOPY_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;

  assign fill_mode    = fill_q;
  assign fill_start   = Fill;
  assign MemWriteData = fill_q ? fill_val_q : MemReadData;
`else
  assign fill_mode    = 1'b0;
  assign fill_start   = 1'b0;
  assign MemWriteData = MemReadData;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    left_d  = left_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef MEMCOPY_FILL_EN
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          left_d = Length;
          if (Length == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            src_d  = SrcAddr;
            dst_d  = DstAddr;
            busy_d = 1'b1;
`ifdef MEMCOPY_FILL_EN
            fill_d     = Fill;
            fill_val_d = FillValue;
`endif
            // Fill mode has nothing to read, so it starts straight at the destination.
            if (fill_start) begin
              state_d = S_WRITE;
              addr_d  = DstAddr;
              wr_d    = 1'b1;
            end else begin
              state_d = S_READ;
              addr_d  = SrcAddr;
              rd_d    = 1'b1;
            end
          end
        end
      end
      S_READ: begin
        src_d = src_q + 1'b1;
        if (Abort) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WRITE;
          addr_d  = dst_q;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_WRITE: begin
        dst_d  = dst_q + 1'b1;
        left_d = left_q - 1'b1;
        if (left_q == 1 || Abort) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (fill_mode) begin
          addr_d = dst_q + 1'b1;
          wr_d   = 1'b1;
          busy_d = 1'b1;
        end else begin
          // src_q already advanced during the preceding READ.
          state_d = S_READ;
          addr_d  = src_q;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      left_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEMCOPY_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      left_q  <= left_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MEMCOPY_FILL_EN
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
`endif
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign BytesLeft = left_q;
  assign Address   = addr_q;
  assign MemWrite  = wr_q;
  assign MemRead   = rd_q;

endmodule
